// File: rtl/button_conditioner.sv
// button_conditioner
//   Conditions a raw mechanical push-button into one clean press event for
//   the traffic-light FSMs. The raw input is synchronised and debounced on
//   both edges. Each accepted press produces a single-cycle pulse. A lockout
//   window follows each accepted press, and presses that qualify inside it
//   are dropped. Saturating counters record accepted and dropped presses
//   for debug.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-high; clears all state
//   btn_raw       raw button, asynchronous to clk, may bounce
//   clear_counts  synchronous clear of press_count and drop_count
//   btn_level     debounced button level (registered)
//   press_pulse   one-cycle pulse per accepted press (registered)
//   lockout       high while the post-press lockout window is active
//   press_count   accepted presses, saturating at all-ones
//   drop_count    presses rejected by lockout, saturating at all-ones
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 16,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_raw,
  input  logic             clear_counts,
  output logic             btn_level,
  output logic             press_pulse,
  output logic             lockout,
  output logic [CNT_W-1:0] press_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  // A zero-cycle lockout still needs a 1-bit counter that simply stays at 0.
  localparam int LK_W  = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;

  localparam logic [DEB_W-1:0] DEB_ONE   = DEB_W'(1);
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LK_W-1:0]  LOCK_ONE  = LK_W'(1);
  localparam logic [LK_W-1:0]  LOCK_LOAD = LK_W'(LOCKOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    PRESSED = 2'd2,
    DISARM  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [DEB_W-1:0] deb_cnt, deb_cnt_nxt;
  logic [LK_W-1:0]  lock_cnt;
  logic             s1, btn_s;
  logic             qualify;
  logic             level_nxt;
  logic             accept;
  logic             drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // ---- Stage: two-flop synchroniser (btn_raw -> s1 -> btn_s) ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1    <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      s1    <= btn_raw;
      btn_s <= s1;
    end
  end

  // ---- Stage: debounce FSM state register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      deb_cnt <= '0;
    end else begin
      state   <= state_nxt;
      deb_cnt <= deb_cnt_nxt;
    end
  end

  // Next state. ARM and DISARM each need DEBOUNCE_CYCLES consecutive
  // samples; entry counts as the first, so the change lands when the
  // counter already shows DEBOUNCE_CYCLES-1 and one more agreeing sample
  // arrives. A contrary sample in DISARM returns straight to PRESSED
  // without raising a new event, so release glitches never re-trigger.
  always_comb begin
    state_nxt   = state;
    deb_cnt_nxt = deb_cnt;
    qualify     = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt   = ARM;
          deb_cnt_nxt = DEB_ONE;
        end
      end
      ARM: begin
        if (!btn_s) begin
          state_nxt = IDLE;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = PRESSED;
          qualify   = 1'b1;
        end else begin
          deb_cnt_nxt = deb_cnt + DEB_ONE;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_nxt   = DISARM;
          deb_cnt_nxt = DEB_ONE;
        end
      end
      DISARM: begin
        if (btn_s) begin
          state_nxt = PRESSED;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = IDLE;
        end else begin
          deb_cnt_nxt = deb_cnt + DEB_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs derived from the FSM. A press qualifying while lock_cnt is
  // still nonzero (including its last cycle, lock_cnt==1) is dropped.
  always_comb begin
    level_nxt = (state_nxt == PRESSED) || (state_nxt == DISARM);
    accept    = qualify && (lock_cnt == '0);
    drop      = qualify && (lock_cnt != '0);
  end

  // ---- Stage: registered outputs, lockout timer and debug counters ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_level   <= 1'b0;
      press_pulse <= 1'b0;
      lock_cnt    <= '0;
      press_count <= '0;
      drop_count  <= '0;
    end else begin
      btn_level   <= level_nxt;
      press_pulse <= accept;

      // A dropped press does not extend the window; the timer keeps running.
      if (accept) begin
        lock_cnt <= LOCK_LOAD;
      end else if (lock_cnt != '0) begin
        lock_cnt <= lock_cnt - LOCK_ONE;
      end

      // Clearing wins over a same-edge event; the pulse itself is unaffected.
      if (clear_counts) begin
        press_count <= '0;
        drop_count  <= '0;
      end else begin
        if (accept) press_count <= sat_inc(press_count);
        if (drop)   drop_count  <= sat_inc(drop_count);
      end
    end
  end

  assign lockout = (lock_cnt != '0);

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  localparam int D  = 4;
  localparam int LA = 16;

  typedef struct {
    int cyc;
    int pcnt;
    int dcnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic       btn_a = 1'b0, clear_a = 1'b0;
  logic       btn_level_a, press_pulse_a, lockout_a;
  logic [7:0] press_count_a, drop_count_a;

  logic       btn_b = 1'b0, clear_b = 1'b0;
  logic       btn_level_b, press_pulse_b, lockout_b;
  logic [1:0] press_count_b, drop_count_b;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  exp_t exp_a[$];
  exp_t exp_b[$];

  button_conditioner #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(LA), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .btn_raw(btn_a), .clear_counts(clear_a),
    .btn_level(btn_level_a), .press_pulse(press_pulse_a), .lockout(lockout_a),
    .press_count(press_count_a), .drop_count(drop_count_a)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .btn_raw(btn_b), .clear_counts(clear_b),
    .btn_level(btn_level_b), .press_pulse(press_pulse_b), .lockout(lockout_b),
    .press_count(press_count_b), .drop_count(drop_count_b)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got === exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp_v, cyc);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press dut_a or dut_b: hold for 'hold' cycles, then release for 'gap'.
  task automatic press(input bit which_b, input int hold, input int gap);
    if (which_b) btn_b = 1'b1; else btn_a = 1'b1;
    ticks(hold);
    if (which_b) btn_b = 1'b0; else btn_a = 1'b0;
    ticks(gap);
  endtask

  // Scoreboard: every observed pulse must match the next expected entry.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!reset && press_pulse_a) begin
      if (exp_a.size() == 0) check("pulse_unexp_a", 1, 0);
      else begin
        e = exp_a.pop_front();
        check("pulse_cyc_a", cyc, e.cyc);
        check("pulse_pcnt_a", press_count_a, e.pcnt);
        check("pulse_dcnt_a", drop_count_a, e.dcnt);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!reset && press_pulse_b) begin
      if (exp_b.size() == 0) check("pulse_unexp_b", 1, 0);
      else begin
        e = exp_b.pop_front();
        check("pulse_cyc_b", cyc, e.cyc);
        check("pulse_pcnt_b", press_count_b, e.pcnt);
        check("pulse_dcnt_b", drop_count_b, e.dcnt);
      end
    end
  end

  initial begin
    int n0, r, c, first_lk, lk_hi;
    bit ok;

    // Reset state
    #1 reset = 1'b1;
    #1;
    check("rst_level", btn_level_a, 0);
    check("rst_pulse", press_pulse_a, 0);
    check("rst_lockout", lockout_a, 0);
    check("rst_pcnt", press_count_a, 0);
    check("rst_dcnt", drop_count_a, 0);
    ticks(3);
    reset = 1'b0;
    ticks(2);

    // Clean press: pulse after E(D+1), lockout LA cycles, level from E(D+1)
    n0 = cyc;
    exp_a.push_back('{n0 + D + 2, 1, 0});
    btn_a = 1'b1;
    first_lk = -1;
    lk_hi = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == D + 1) check("clean_lvl_pre", btn_level_a, 0);
      if (k == D + 2) check("clean_lvl_post", btn_level_a, 1);
      if (lockout_a) begin
        lk_hi++;
        if (first_lk < 0) first_lk = k;
      end
    end
    check("clean_lock_first", first_lk, D + 2);
    check("clean_lock_len", lk_hi, LA);
    check("clean_pcnt", press_count_a, 1);
    // Release debounce latency
    btn_a = 1'b0;
    for (int k = 1; k <= D + 2; k++) begin
      @(negedge clk);
      if (k == D + 1) check("rel_lvl_hold", btn_level_a, 1);
      if (k == D + 2) check("rel_lvl_fall", btn_level_a, 0);
    end
    ticks(6);

    // Clear, then bounce reject: 1,1,1,0 x10 then 0
    clear_a = 1'b1;
    ticks(1);
    clear_a = 1'b0;
    check("clear_pcnt", press_count_a, 0);
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      btn_a = (i % 4 != 3);
      @(negedge clk);
      if (btn_level_a) ok = 1'b0;
    end
    btn_a = 1'b0;
    ticks(10);
    check("bounce_level_low", ok, 1);
    check("bounce_pcnt", press_count_a, 0);
    check("bounce_dcnt", drop_count_a, 0);

    // Spam: second press qualifies on the edge where lock_cnt==1
    n0 = cyc;
    exp_a.push_back('{n0 + D + 2, 1, 0});
    press(1'b0, 8, 8);
    btn_a = 1'b1;               // now at n0+16, qualifies at n0+22
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 5) begin
        check("spam_lock_last", lockout_a, 1);
        check("spam_dcnt_pre", drop_count_a, 0);
      end
      if (k == 6) begin
        check("spam_lock_off", lockout_a, 0);
        check("spam_dcnt_post", drop_count_a, 1);
        check("spam_no_pulse", press_pulse_a, 0);
      end
    end
    btn_a = 1'b0;
    ticks(12);
    exp_a.push_back('{cyc + D + 2, 2, 1});
    press(1'b0, 8, 12);
    check("spam_pcnt", press_count_a, 2);
    check("spam_dcnt", drop_count_a, 1);
    ticks(6);

    // Release debounce with a 2-cycle high glitch inside DISARM
    exp_a.push_back('{cyc + D + 2, 3, 1});
    btn_a = 1'b1;
    ticks(24);
    r = cyc;
    btn_a = 1'b0;
    ok = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k <= 8 && !btn_level_a) ok = 1'b0;
      if (k == 9) check("glitch_fall", btn_level_a, 0);
      btn_a = (k == 1 || k == 2);
    end
    check("glitch_held", ok, 1);
    ticks(6);
    check("glitch_pcnt", press_count_a, 3);

    // Reset mid-lockout with the button held
    exp_a.push_back('{cyc + D + 2, 4, 1});
    btn_a = 1'b1;
    ticks(D + 5);
    check("mid_lock_pre", lockout_a, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_level", btn_level_a, 0);
    check("mid_rst_pulse", press_pulse_a, 0);
    check("mid_rst_lockout", lockout_a, 0);
    check("mid_rst_pcnt", press_count_a, 0);
    check("mid_rst_dcnt", drop_count_a, 0);
    ticks(2);
    reset = 1'b0;
    c = cyc;
    exp_a.push_back('{c + D + 2, 1, 0});
    ticks(D + 4);
    check("post_rst_level", btn_level_a, 1);
    check("post_rst_pcnt", press_count_a, 1);
    btn_a = 1'b0;
    ticks(25);

    // Saturation on CNT_W=2, no lockout; clear on the fifth qualify edge
    for (int i = 1; i <= 5; i++) begin
      if (i < 5) begin
        exp_b.push_back('{cyc + D + 2, (i > 3) ? 3 : i, 0});
        press(1'b1, 8, 10);
      end else begin
        exp_b.push_back('{cyc + D + 2, 0, 0});
        btn_b = 1'b1;
        ticks(D + 1);
        clear_b = 1'b1;
        ticks(1);
        clear_b = 1'b0;
        ticks(3);
        btn_b = 1'b0;
        ticks(10);
      end
      if (i == 4) check("sat_pcnt", press_count_b, 3);
    end
    check("sat_clear_pcnt", press_count_b, 0);
    check("sat_dcnt", drop_count_b, 0);
    check("sat_no_lockout", lockout_b, 0);

    check("pending_a", exp_a.size(), 0);
    check("pending_b", exp_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
